// File: rtl/alu_if.sv
// ALU operand/response bundle: the BIST (or any driver) presents a, b, ops and the
// combinational ALU returns out plus flags in the same cycle.
package alu_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
endpackage

interface alu_if;
    import alu_pkg::*;

    word_t  a;
    word_t  b;
    aluop_t ops;
    word_t  out;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport tb     (output a, b, ops, input out, negative, overflow, zero);
    modport alu    (input a, b, ops, output out, negative, overflow, zero);
    modport master (output a, b, ops, input out, negative, overflow, zero);
    modport slave  (input a, b, ops, output out, negative, overflow, zero);
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: issues NVEC LFSR-generated vectors, one per cycle, and
// compresses every response into a 32-bit MISR that is compared against GOLDEN.
module alu_bist
    import alu_pkg::*;
#(
    parameter int unsigned NVEC   = 1024,
    parameter logic [31:0] SEED_A = 32'hACE12468,
    parameter logic [31:0] SEED_B = 32'h1357BDF0,
    parameter logic [31:0] GOLDEN = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    alu_if.tb           aluif,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature,
    output logic        pass
);

    localparam int unsigned    CW   = $clog2(NVEC + 1);
    localparam logic [CW-1:0] LAST = CW'(NVEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   lfsr_a_q, lfsr_a_d;
    logic [31:0]   lfsr_b_q, lfsr_b_d;
    word_t         a_q, a_d;
    word_t         b_q, b_d;
    aluop_t        ops_q, ops_d;
    logic [31:0]   sig_q, sig_d;
    logic [31:0]   resp;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            a_q      <= '0;
            b_q      <= '0;
            ops_q    <= ALU_SLL;
            sig_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ops_q    <= ops_d;
            sig_q    <= sig_d;
        end
    end

    // The LFSR registers run one step ahead of a/b: they hold the next vector to issue.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        a_d      = a_q;
        b_d      = b_q;
        ops_d    = ops_q;
        sig_d    = sig_q;
        resp     = aluif.out ^ {29'b0, aluif.negative, aluif.overflow, aluif.zero};
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    a_d      = SEED_A;
                    b_d      = SEED_B;
                    ops_d    = ALU_SLL;
                    lfsr_a_d = lfsr_step(SEED_A);
                    lfsr_b_d = lfsr_step(SEED_B);
                    sig_d    = '0;
                end
            end
            RUN: begin
                sig_d = misr_step(sig_q, resp);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    a_d      = lfsr_a_q;
                    b_d      = lfsr_b_q;
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    ops_d    = (ops_q == ALU_SLTU) ? ALU_SLL : aluop_t'(ops_q + 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        pass = done && (sig_q == GOLDEN);
    end

    assign aluif.a   = a_q;
    assign aluif.b   = b_q;
    assign aluif.ops = ops_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: several instances with different parameters, each
// bound to a stub or reference ALU, checked against hand-computed or modelled values.
module tb_alu_bist;
    import alu_pkg::*;

    localparam logic [31:0] DEF_SA = 32'hACE12468;
    localparam logic [31:0] DEF_SB = 32'h1357BDF0;

    // Reference ALU result: {overflow, out}
    function automatic logic [32:0] alu_eval(input logic [31:0] a, input logic [31:0] b, input int op);
        logic [31:0] o;
        logic        v;
        v = 1'b0;
        case (op)
            0: o = a << b[4:0];
            1: o = a >> b[4:0];
            2: begin o = a + b; v = (a[31] == b[31]) && (o[31] != a[31]); end
            3: begin o = a - b; v = (a[31] != b[31]) && (o[31] != a[31]); end
            4: o = a & b;
            5: o = a | b;
            6: o = a ^ b;
            7: o = ~(a | b);
            8: o = {31'b0, $signed(a) < $signed(b)};
            default: o = {31'b0, a < b};
        endcase
        return {v, o};
    endfunction

    // mode 0: out=a^b, 1: out=a, 2: reference ALU, 3: reference ALU with zero stuck at 1
    function automatic logic [31:0] model_sig(input int n, input logic [31:0] sa, input logic [31:0] sb, input int mode);
        logic [31:0] a, b, o, sig, d;
        logic [32:0] r;
        logic        neg, ovf, zr;
        a = sa;
        b = sb;
        sig = 32'h0;
        for (int k = 0; k < n; k++) begin
            r = alu_eval(a, b, k % 10);
            if (mode == 0) begin
                o = a ^ b; neg = 1'b0; ovf = 1'b0; zr = 1'b0;
            end else if (mode == 1) begin
                o = a; neg = 1'b0; ovf = 1'b0; zr = 1'b0;
            end else begin
                o = r[31:0]; neg = o[31]; ovf = r[32]; zr = (o == 32'h0) || (mode == 3);
            end
            d = o ^ {29'b0, neg, ovf, zr};
            sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ d;
            a = (a >> 1) ^ (a[0] ? 32'h80200003 : 32'h0);
            b = (b >> 1) ^ (b[0] ? 32'h80200003 : 32'h0);
        end
        return sig;
    endfunction

    localparam logic [31:0] GOLDEN_REAL = model_sig(16, DEF_SA, DEF_SB, 2);

    logic CLK = 1'b0;
    logic rst_n, nrst4;
    logic start1, start2, start3, start4, start5;
    logic busy1, busy2, busy3, busy4, busy5, busy6;
    logic done1, done2, done3, done4, done5, done6;
    logic pass1, pass2, pass3, pass4, pass5, pass6;
    logic [31:0] sig1, sig2, sig3, sig4, sig5, sig6;
    logic [32:0] r5, r6;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_if if1();
    alu_if if2();
    alu_if if3();
    alu_if if4();
    alu_if if5();
    alu_if if6();

    always_comb begin
        if1.out = if1.a ^ if1.b; if1.negative = 1'b0; if1.overflow = 1'b0; if1.zero = 1'b0;
        if2.out = if2.a;         if2.negative = 1'b0; if2.overflow = 1'b0; if2.zero = 1'b0;
        if3.out = if3.a ^ if3.b; if3.negative = 1'b0; if3.overflow = 1'b0; if3.zero = 1'b0;
        if4.out = if4.a ^ if4.b; if4.negative = 1'b0; if4.overflow = 1'b0; if4.zero = 1'b0;
        r5 = alu_eval(if5.a, if5.b, int'(if5.ops));
        if5.out = r5[31:0]; if5.overflow = r5[32]; if5.negative = r5[31]; if5.zero = (r5[31:0] == 32'h0);
        r6 = alu_eval(if6.a, if6.b, int'(if6.ops));
        if6.out = r6[31:0]; if6.overflow = r6[32]; if6.negative = r6[31]; if6.zero = 1'b1;
    end

    alu_bist #(.NVEC(1), .SEED_A(32'd3), .SEED_B(32'd4), .GOLDEN(32'd7)) u1 (
        .CLK(CLK), .nRST(rst_n), .start(start1), .aluif(if1),
        .busy(busy1), .done(done1), .signature(sig1), .pass(pass1));
    alu_bist #(.NVEC(2), .SEED_A(32'd1)) u2 (
        .CLK(CLK), .nRST(rst_n), .start(start2), .aluif(if2),
        .busy(busy2), .done(done2), .signature(sig2), .pass(pass2));
    alu_bist #(.NVEC(12)) u3 (
        .CLK(CLK), .nRST(rst_n), .start(start3), .aluif(if3),
        .busy(busy3), .done(done3), .signature(sig3), .pass(pass3));
    alu_bist u4 (
        .CLK(CLK), .nRST(nrst4), .start(start4), .aluif(if4),
        .busy(busy4), .done(done4), .signature(sig4), .pass(pass4));
    alu_bist #(.NVEC(16), .GOLDEN(GOLDEN_REAL)) u5 (
        .CLK(CLK), .nRST(rst_n), .start(start5), .aluif(if5),
        .busy(busy5), .done(done5), .signature(sig5), .pass(pass5));
    alu_bist #(.NVEC(16), .GOLDEN(GOLDEN_REAL)) u6 (
        .CLK(CLK), .nRST(rst_n), .start(start5), .aluif(if6),
        .busy(busy6), .done(done6), .signature(sig6), .pass(pass6));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulses one start for a single edge; returns at the sample point just after that edge.
    task automatic applyStimulus(input int which);
        @(negedge CLK);
        case (which)
            1: start1 = 1'b1;
            2: start2 = 1'b1;
            4: start4 = 1'b1;
            5: start5 = 1'b1;
            default: ;
        endcase
        @(negedge CLK);
        start1 = 1'b0; start2 = 1'b0; start4 = 1'b0; start5 = 1'b0;
    endtask

    task automatic waitRun4(input bit repulse, output int n);
        n = 0;
        while (busy4 && n < 2000) begin
            n++;
            if (repulse && n == 5) start4 = 1'b1;
            if (n == 6) start4 = 1'b0;
            @(negedge CLK);
        end
    endtask

    initial begin
        int n;
        logic [31:0] sig_def;
        sig_def = model_sig(1024, DEF_SA, DEF_SB, 0);
        start1 = 0; start2 = 0; start3 = 0; start4 = 0; start5 = 0;
        rst_n = 1'b1; nrst4 = 1'b1;
        #1;
        rst_n = 1'b0; nrst4 = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        checkOutput("rst_done", 32'(done1), 32'd0);
        checkOutput("rst_sig", sig1, 32'h0);
        checkOutput("rst_a", if1.a, 32'h0);
        checkOutput("rst_b", if1.b, 32'h0);
        checkOutput("rst_ops", 32'(if1.ops), 32'(ALU_SLL));
        rst_n = 1'b1; nrst4 = 1'b1;

        $display("[TB] NVEC=1 run");
        applyStimulus(1);
        checkOutput("u1_e0_busy", 32'(busy1), 32'd1);
        checkOutput("u1_e0_a", if1.a, 32'd3);
        checkOutput("u1_e0_b", if1.b, 32'd4);
        checkOutput("u1_e0_sig", sig1, 32'h0);
        @(negedge CLK);
        checkOutput("u1_e1_busy", 32'(busy1), 32'd0);
        checkOutput("u1_e1_done", 32'(done1), 32'd1);
        checkOutput("u1_e1_sig", sig1, 32'h00000007);
        checkOutput("u1_pass", 32'(pass1), 32'd1);
        repeat (3) @(negedge CLK);
        checkOutput("u1_hold_sig", sig1, 32'h00000007);
        checkOutput("u1_hold_a", if1.a, 32'd3);

        $display("[TB] NVEC=2 out=a run");
        applyStimulus(2);
        checkOutput("u2_v0_a", if2.a, 32'h00000001);
        @(negedge CLK);
        checkOutput("u2_v1_a", if2.a, 32'h80200003);
        checkOutput("u2_v1_sig", sig2, 32'h00000001);
        @(negedge CLK);
        checkOutput("u2_sig", sig2, 32'h80200001);
        checkOutput("u2_done", 32'(done2), 32'd1);
        checkOutput("u2_pass", 32'(pass2), 32'd0);

        $display("[TB] NVEC=12 op sequence with start held");
        @(negedge CLK);
        start3 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("u3_ops%0d", i), 32'(if3.ops), 32'(i % 10));
            checkOutput($sformatf("u3_busy%0d", i), 32'(busy3), 32'd1);
        end
        @(negedge CLK);
        checkOutput("u3_end_busy", 32'(busy3), 32'd0);
        checkOutput("u3_end_done", 32'(done3), 32'd1);
        checkOutput("u3_sig", sig3, model_sig(12, DEF_SA, DEF_SB, 0));
        @(negedge CLK);
        checkOutput("u3_restart_busy", 32'(busy3), 32'd1);
        checkOutput("u3_restart_a", if3.a, DEF_SA);
        checkOutput("u3_restart_ops", 32'(if3.ops), 32'(ALU_SLL));
        start3 = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("u3_rerun_done", 32'(done3), 32'd1);
        checkOutput("u3_rerun_sig", sig3, model_sig(12, DEF_SA, DEF_SB, 0));

        $display("[TB] default NVEC with start re-pulsed mid-run");
        applyStimulus(4);
        waitRun4(1'b1, n);
        checkOutput("u4_len", 32'(n), 32'd1024);
        checkOutput("u4_done", 32'(done4), 32'd1);
        checkOutput("u4_sig", sig4, sig_def);
        applyStimulus(4);
        waitRun4(1'b0, n);
        checkOutput("u4_len2", 32'(n), 32'd1024);
        checkOutput("u4_sig2", sig4, sig_def);

        $display("[TB] reset mid-run");
        applyStimulus(4);
        repeat (99) @(negedge CLK);
        #2;
        nrst4 = 1'b0;
        #1;
        checkOutput("u4_abort_busy", 32'(busy4), 32'd0);
        checkOutput("u4_abort_done", 32'(done4), 32'd0);
        checkOutput("u4_abort_sig", sig4, 32'h0);
        checkOutput("u4_abort_ops", 32'(if4.ops), 32'(ALU_SLL));
        @(negedge CLK);
        nrst4 = 1'b1;
        applyStimulus(4);
        waitRun4(1'b0, n);
        checkOutput("u4_len3", 32'(n), 32'd1024);
        checkOutput("u4_sig3", sig4, sig_def);

        $display("[TB] reference ALU against golden");
        applyStimulus(5);
        repeat (16) @(negedge CLK);
        checkOutput("u5_done", 32'(done5), 32'd1);
        checkOutput("u5_sig", sig5, GOLDEN_REAL);
        checkOutput("u5_pass", 32'(pass5), 32'd1);
        checkOutput("u6_done", 32'(done6), 32'd1);
        checkOutput("u6_pass", 32'(pass6), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
